// File: rtl/apb_slave.sv
// apb_slave: APB3-style slave over an 8-bit register memory with programmable wait states.
// Define APB_SLAVE_WPROT_EN to make addresses RO_BASE..MEM_DEPTH-1 read-only.
module apb_slave #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0,
    parameter int RO_BASE     = 192
) (
    input  logic       clk,
    input  logic       preset,
    input  logic       psel0,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    input  logic [7:0] paddr,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] prdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef APB_SLAVE_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t         state;
    state_t         stateNext;
    logic [3:0]     waitCnt;
    logic [3:0]     waitCntNext;
    logic           preadyNext;
    logic           doXfer;
    logic           inRange;
    logic           wrProt;
    logic           errNow;
    logic [AW-1:0]  memIdx;
    logic [7:0]     mem [0:MEM_DEPTH-1];

    // Address decode: range check, optional read-only window, memory index.
    always_comb begin
        inRange = ({1'b0, paddr} < 9'(MEM_DEPTH));
        wrProt  = WPROT_ON && pwrite && ({1'b0, paddr} >= 9'(RO_BASE));
        errNow  = !inRange || wrProt;
        memIdx  = paddr[AW-1:0];
    end

    // Next-state logic; doXfer marks the single edge where the transfer commits with pready.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        preadyNext  = 1'b0;
        doXfer      = 1'b0;
        case (state)
            IDLE, SETUP: begin
                if (!psel0) begin
                    stateNext = IDLE;
                end else if (!penable) begin
                    stateNext = SETUP;
                end else begin
                    stateNext   = ACCESS;
                    waitCntNext = '0;
                    if (WAIT_STATES == 0) begin
                        preadyNext = 1'b1;
                        doXfer     = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!psel0) begin
                    stateNext = IDLE;
                end else if (pready) begin
                    stateNext = DONE;
                end else begin
                    waitCntNext = waitCnt + 4'd1;
                    if (({1'b0, waitCnt} + 5'd1) == 5'(WAIT_STATES)) begin
                        preadyNext = 1'b1;
                        doXfer     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!psel0) begin
                    stateNext = IDLE;
                end else if (!penable) begin
                    stateNext = SETUP;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!preset) begin
            state   <= IDLE;
            waitCnt <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            pready  <= preadyNext;
            pslverr <= doXfer && errNow;
            if (doXfer && !pwrite) begin
                prdata <= inRange ? mem[memIdx] : 8'h00;
            end
        end
    end

    // Register memory; reset wipes every location.
    always_ff @(posedge clk) begin
        if (!preset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doXfer && pwrite && inRange && !wrProt) begin
            mem[memIdx] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed checks of apb_slave with zero wait states (A), two wait states (B)
// and a 256-deep instance (C) for the read-only window when APB_SLAVE_WPROT_EN is defined.
module tb_apb_slave;

    logic       clk = 1'b0;
    logic       preset = 1'b0;
    logic       pselA = 1'b0;
    logic       pselB = 1'b0;
    logic       pselC = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = '0;
    logic [7:0] paddr = '0;
    logic       preadyA, preadyB, preadyC;
    logic       pslverrA, pslverrB, pslverrC;
    logic [7:0] prdataA, prdataB, prdataC;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_slave #(.MEM_DEPTH(64), .WAIT_STATES(0), .RO_BASE(192)) dutA (
        .clk(clk), .preset(preset), .psel0(pselA), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .paddr(paddr), .pready(preadyA), .pslverr(pslverrA), .prdata(prdataA));

    apb_slave #(.MEM_DEPTH(64), .WAIT_STATES(2), .RO_BASE(192)) dutB (
        .clk(clk), .preset(preset), .psel0(pselB), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .paddr(paddr), .pready(preadyB), .pslverr(pslverrB), .prdata(prdataB));

    apb_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .RO_BASE(192)) dutC (
        .clk(clk), .preset(preset), .psel0(pselC), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .paddr(paddr), .pready(preadyC), .pslverr(pslverrC), .prdata(prdataC));

    function automatic logic readyOf(input int which);
        return (which == 0) ? preadyA : (which == 1) ? preadyB : preadyC;
    endfunction

    function automatic logic errOf(input int which);
        return (which == 0) ? pslverrA : (which == 1) ? pslverrB : pslverrC;
    endfunction

    function automatic logic [7:0] dataOf(input int which);
        return (which == 0) ? prdataA : (which == 1) ? prdataB : prdataC;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One APB access to the chosen slave, penable held for holdCycles edges; records pready pulses.
    task automatic applyStimulus(input int which, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] data, input bit skipSetup, input int holdCycles,
                                 output int pulses, output int firstIdx,
                                 output logic err, output logic [7:0] rdata);
        pulses = 0;
        firstIdx = 0;
        err = 1'b0;
        rdata = '0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        pselA = (which == 0);
        pselB = (which == 1);
        pselC = (which == 2);
        if (!skipSetup) begin
            penable = 1'b0;
            @(posedge clk); #1;
        end
        penable = 1'b1;
        for (int i = 1; i <= holdCycles; i++) begin
            @(posedge clk); #1;
            if (readyOf(which)) begin
                pulses++;
                if (firstIdx == 0) begin
                    firstIdx = i;
                    err = errOf(which);
                    rdata = dataOf(which);
                end
            end
        end
        pselA = 1'b0;
        pselB = 1'b0;
        pselC = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    int pulses, firstIdx;
    logic err;
    logic [7:0] rdata;

    initial begin
        repeat (2) @(posedge clk);
        #1 preset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_pready", preadyA, 0);
        checkOutput("reset_pslverr", pslverrA, 0);
        checkOutput("reset_prdata", prdataA, 0);

        applyStimulus(0, 1'b1, 8'd35, 8'd56, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("wr35_pulses", pulses, 1);
        checkOutput("wr35_latency", firstIdx, 1);
        checkOutput("wr35_err", err, 0);
        applyStimulus(0, 1'b1, 8'd25, 8'd78, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("wr25_pulses", pulses, 1);
        checkOutput("wr25_err", err, 0);

        applyStimulus(0, 1'b0, 8'd35, 8'd0, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("rd35_pulses", pulses, 1);
        checkOutput("rd35_data", rdata, 56);
        checkOutput("rd35_hold", prdataA, 56);
        applyStimulus(0, 1'b0, 8'd25, 8'd0, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("rd25_data", rdata, 78);
        checkOutput("rd25_err", err, 0);

        applyStimulus(1, 1'b1, 8'd3, 8'hA5, 1'b0, 6, pulses, firstIdx, err, rdata);
        checkOutput("ws2_wr_pulses", pulses, 1);
        checkOutput("ws2_wr_latency", firstIdx, 3);
        applyStimulus(1, 1'b0, 8'd3, 8'd0, 1'b0, 6, pulses, firstIdx, err, rdata);
        checkOutput("ws2_rd_latency", firstIdx, 3);
        checkOutput("ws2_rd_data", rdata, 8'hA5);

        applyStimulus(0, 1'b1, 8'd200, 8'h99, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("oor_wr_pulses", pulses, 1);
        checkOutput("oor_wr_err", err, 1);
        checkOutput("oor_err_clears", pslverrA, 0);
        applyStimulus(0, 1'b0, 8'd200, 8'd0, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("oor_rd_err", err, 1);
        checkOutput("oor_rd_data", rdata, 0);
        applyStimulus(0, 1'b0, 8'd8, 8'd0, 1'b0, 4, pulses, firstIdx, err, rdata);
        checkOutput("oor_no_alias", rdata, 0);

        applyStimulus(0, 1'b1, 8'd63, 8'h3C, 1'b1, 3, pulses, firstIdx, err, rdata);
        checkOutput("nosetup_wr_pulses", pulses, 1);
        checkOutput("top_addr_err", err, 0);
        applyStimulus(0, 1'b0, 8'd63, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("top_addr_rd", rdata, 8'h3C);

        applyStimulus(2, 1'b1, 8'd191, 8'h33, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("c_wr191_err", err, 0);
        applyStimulus(2, 1'b0, 8'd191, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("c_rd191", rdata, 8'h33);
        applyStimulus(2, 1'b1, 8'd200, 8'h5A, 1'b0, 3, pulses, firstIdx, err, rdata);
`ifdef APB_SLAVE_WPROT_EN
        checkOutput("c_wr200_err", err, 1);
        applyStimulus(2, 1'b0, 8'd200, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("c_rd200", rdata, 8'h00);
        checkOutput("c_rd200_err", err, 0);
`else
        checkOutput("c_wr200_err", err, 0);
        applyStimulus(2, 1'b0, 8'd200, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("c_rd200", rdata, 8'h5A);
        checkOutput("c_rd200_err", err, 0);
`endif

        // Abort: deselect while B is still waiting, so nothing may commit.
        applyStimulus(1, 1'b1, 8'd4, 8'h77, 1'b1, 1, pulses, firstIdx, err, rdata);
        checkOutput("abort_pulses", pulses, 0);
        applyStimulus(1, 1'b0, 8'd4, 8'd0, 1'b0, 6, pulses, firstIdx, err, rdata);
        checkOutput("abort_no_write", rdata, 0);

        // Reset in the middle of a B access.
        pselB = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd35; pwdata = 8'h22;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_pready", preadyB, 0);
        checkOutput("midrst_pslverr", pslverrB, 0);
        preset = 1'b1;
        pselB = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 8'd35, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("rst_clears_a35", rdata, 0);
        applyStimulus(0, 1'b0, 8'd63, 8'd0, 1'b0, 3, pulses, firstIdx, err, rdata);
        checkOutput("rst_clears_a63", rdata, 0);
        applyStimulus(1, 1'b0, 8'd35, 8'd0, 1'b0, 6, pulses, firstIdx, err, rdata);
        checkOutput("rst_no_commit_b35", rdata, 0);
        checkOutput("rst_b_pulses", pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
